// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I sequencing controller: Moore FSM plus main/ALU/immediate decode.
// Optional feature macro ILLEGAL_OP_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_op.
module rv_multicycle_ctrl #(
   parameter int unsigned FETCH_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic       instr_done,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic       illegal_op,
`endif
   output logic       mem_timeout
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(FETCH_WAIT_MAX);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;

   logic       pc_update, branch;
   logic [1:0] alu_op;
   logic       mem_write_raw, ir_write_raw, reg_write_raw, done_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Fetch stall watchdog: saturating count of consecutive not-ready fetch cycles.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      if (state_q == S_FETCH) begin
         if (mem_ready) begin
            wait_cnt_d = '0;
         end else begin
            if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (wait_cnt_d >= WAIT_LIMIT) timeout_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      alu_op        = 2'b00;
      pc_update     = 1'b0;
      branch        = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      done_raw      = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op    = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            ALUSrcB      = 2'b10;
            ResultSrc    = 2'b10;
            ir_write_raw = mem_ready;
            pc_update    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  state_d  = S_TRAP;
`else
                  done_raw = 1'b1;
                  state_d  = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc     = 2'b01;
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
            if (mem_ready) begin
               done_raw = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
            state_d       = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA  = 2'b10;
            alu_op   = 2'b01;
            branch   = 1'b1;
            done_raw = 1'b1;
            state_d  = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP: begin
            illegal_op = 1'b1;
            state_d    = S_TRAP;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_STORE:  ImmSrc = 2'b01;
         OP_BRANCH: ImmSrc = 2'b10;
         OP_JAL:    ImmSrc = 2'b11;
         default:   ImmSrc = 2'b00;
      endcase
   end

   // Strobes are squashed while reset is held so an aborted store never reaches memory.
   assign PCWrite     = ~reset & (pc_update | (branch & zero));
   assign MemWrite    = ~reset & mem_write_raw;
   assign IRWrite     = ~reset & ir_write_raw;
   assign RegWrite    = ~reset & reg_write_raw;
   assign instr_done  = ~reset & done_raw;
   assign mem_timeout = ~reset & timeout_q;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Sequencing controller for a multicycle build of the RV32I core: shares one ALU and one unified memory port across fetch, address and execute steps.
- Moore FSM steps the datapath through each instruction.
- Decodes opcode/funct fields into mux selects, write strobes and a 3-bit ALU operation.
- Stretches memory-access states on a ready handshake.
- Sits beside the datapath in the core top, replacing the single-cycle control path.

Parameters:
FETCH_WAIT_MAX, 15, max consecutive not-ready cycles in FETCH before mem_timeout asserts (4-bit counter, saturating).

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous active-high reset
op  in  7  instr[6:0], from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepts/returns data this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  out  2  00=rs2, 01=imm, 10=const 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instr_done  out  1  one-cycle pulse on the last state of each instruction
mem_timeout  out  1  sticky flag: fetch wait exceeded FETCH_WAIT_MAX

Behaviour:
- State register resets asynchronously to FETCH.
- While reset is high, force PCWrite, MemWrite, IRWrite, RegWrite, instr_done and mem_timeout to 0. Other outputs take their FETCH values.
- Outputs are decoded combinationally from state, plus zero/mem_ready where stated.
- Signals not listed for a state are 0.
- Internal signals: PCUpdate, Branch, ALUOp.
- PCWrite = PCUpdate | (Branch & zero).
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, else 00.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - mem_ready=0: stay in FETCH and increment the wait counter. When the counter reaches FETCH_WAIT_MAX, set mem_timeout (sticky until reset).
  - mem_ready=1: go to DECODE and clear the counter.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> ILLEGAL handling (see Optional Feature)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1. On that cycle instr_done=1 and next state is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB.
- ALU decode:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3: 000 -> 001 if (funct7b5 & op[5]) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
  - ALUOp 11 -> 000.
- Reset asserted mid-instruction (including a pending MemWrite) aborts immediately; state returns to FETCH asynchronously.
- Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unknown op in DECODE enters TRAP.
  - TRAP holds all strobes 0 and asserts an extra output illegal_op=1.
  - TRAP persists until reset.
- Undefined: an unknown op goes from DECODE to FETCH as a NOP with instr_done=1 in DECODE. The illegal_op port is absent.

Test Plan:
- Reset high then low with mem_ready=1 -> state FETCH; during reset all strobes are 0; first post-reset cycle has IRWrite=1, PCWrite=1.
- lw x1,4(x2) (op 0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5; instr_done pulses once.
- sub (op 0110011, funct3 000, funct7b5 1) -> ALUControl=001 in EXECR; same with funct7b5=0 -> 000. slt (funct3 010) -> 101.
- beq with zero=1 -> PCWrite=1 in BEQ; with zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, instr_done only on the ready cycle. Fetch stalled 15 cycles -> mem_timeout=1 and stays 1.
- op 1111111 -> with ILLEGAL_OP_TRAP_EN: TRAP, illegal_op=1, held until reset. Without it: back to FETCH after DECODE, no RegWrite/MemWrite.
